// File: rtl/du_mem_dumper_pkg.sv
// Shared debug-unit definitions: dumper state encoding, default dump geometry
// and the word-index to byte-address helper.
package du_mem_dumper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } dump_state_e;

    localparam int unsigned DUMP_N_WORDS_DEF   = 64;
    localparam int unsigned DUMP_ADDR_STEP_DEF = 4;

    // The debug read port is only 8 bits wide, so addresses wrap modulo 256.
    function automatic logic [7:0] word_addr(input int unsigned word, input int unsigned step);
        int unsigned full;
        full = word * step;
        return full[7:0];
    endfunction

endpackage

// File: rtl/du_mem_dumper.sv
// Streams N_WORDS data-memory words out of the MEM-stage debug read port to the
// UART transmitter, MSB byte first, with ready/valid flow control.
module du_mem_dumper
    import du_mem_dumper_pkg::*;
#(
    parameter int unsigned N_WORDS   = DUMP_N_WORDS_DEF,
    parameter int unsigned ADDR_STEP = DUMP_ADDR_STEP_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic [7:0]  o_du_mem_addr,
    input  logic [31:0] i_du_mem_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned WCNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(N_WORDS - 1);

    dump_state_e       state_q, state_d;
    logic [WCNT_W-1:0] word_q, word_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       shift_q, shift_d;
    logic [7:0]        addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

    assign accept = valid_q && i_tx_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    word_d  = '0;
                    addr_d  = word_addr(32'd0, ADDR_STEP);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: state_d = ST_LATCH;
            ST_LATCH: begin
                // Read data is valid here: address has been stable for a full cycle.
                shift_d = i_du_mem_data;
                byte_d  = 2'd0;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (accept) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        valid_d = 1'b0;
                        if (word_q == LAST_WORD) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            word_d  = word_q + 1'b1;
                            addr_d  = word_addr(32'(word_q) + 32'd1, ADDR_STEP);
                            state_d = ST_ADDR;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_du_mem_addr = addr_q;
    assign o_tx_data     = shift_q[31:24];
    assign o_tx_valid    = valid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_du_mem_dumper.sv
// Scoreboard bench: three dumpers (2, 64 and 65 words) fed by a registered
// memory model; a negedge monitor pops expected bytes on every handshake.
module tb_du_mem_dumper;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        rst     [3];
    logic        start   [3];
    logic        ready   [3];
    logic [7:0]  addr    [3];
    logic [31:0] mem_data[3];
    logic [7:0]  tx_data [3];
    logic        tx_valid[3];
    logic        busy    [3];
    logic        done    [3];

    logic [7:0]  exp_q   [3][$];
    int          acc     [3];
    int          done_cnt[3];
    int          done_cyc[3];
    logic        prev_stall[3];
    logic [7:0]  prev_data [3];
    logic        tog = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    du_mem_dumper #(.N_WORDS(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst[0]), .i_start(start[0]), .o_du_mem_addr(addr[0]),
        .i_du_mem_data(mem_data[0]), .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]),
        .i_tx_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]));

    du_mem_dumper #(.N_WORDS(64)) u_dut64 (
        .i_clk(clk), .i_reset(rst[1]), .i_start(start[1]), .o_du_mem_addr(addr[1]),
        .i_du_mem_data(mem_data[1]), .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]),
        .i_tx_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]));

    du_mem_dumper #(.N_WORDS(65)) u_dut65 (
        .i_clk(clk), .i_reset(rst[2]), .i_start(start[2]), .o_du_mem_addr(addr[2]),
        .i_du_mem_data(mem_data[2]), .o_tx_data(tx_data[2]), .o_tx_valid(tx_valid[2]),
        .i_tx_ready(ready[2]), .o_busy(busy[2]), .o_done(done[2]));

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        case (a)
            8'd0:    return 32'h11223344;
            8'd4:    return 32'hAABBCCDD;
            default: return {a, ~a, a ^ 8'h5A, 8'hC3};
        endcase
    endfunction

    // Synchronous-read memory: data follows the address one edge later.
    always @(posedge clk)
        for (int i = 0; i < 3; i++) mem_data[i] <= mem_word(addr[i]);

    always @(posedge clk) if (tog) begin #1 ready[0] = ~ready[0]; end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                prev_stall[i] = 1'b0;
            end else begin
                if (prev_stall[i]) begin
                    checks++;
                    if (!(tx_valid[i] && tx_data[i] == prev_data[i])) begin
                        errors++;
                        $display("FAIL stall_hold dut%0d: valid=%0b data=%02h, required valid=1 data=%02h",
                                 i, tx_valid[i], tx_data[i], prev_data[i]);
                    end
                end
                if (tx_valid[i] && ready[i]) begin
                    checks++;
                    acc[i]++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte dut%0d: got %02h, required no byte", i, tx_data[i]);
                    end else begin
                        logic [7:0] e;
                        e = exp_q[i].pop_front();
                        if (tx_data[i] !== e) begin
                            errors++;
                            $display("FAIL byte dut%0d #%0d: got %02h, required %02h", i, acc[i] - 1, tx_data[i], e);
                        end
                    end
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                prev_stall[i] = tx_valid[i] && !ready[i];
                prev_data[i]  = tx_data[i];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_dump(input int id, input int n);
        for (int w = 0; w < n; w++) begin
            int unsigned full;
            logic [7:0]  a;
            logic [31:0] d;
            full = w * 4;
            a = full[7:0];
            d = mem_word(a);
            exp_q[id].push_back(d[31:24]);
            exp_q[id].push_back(d[23:16]);
            exp_q[id].push_back(d[15:8]);
            exp_q[id].push_back(d[7:0]);
        end
    endtask

    task automatic pulse_start(input int id, output int sample_cyc);
        start[id]  = 1'b1;
        sample_cyc = cyc + 1;
        step();
        start[id]  = 1'b0;
    endtask

    task automatic wait_done(input int id, input int d0, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (done_cnt[id] != d0) break;
            step();
        end
        if (done_cnt[id] == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d: no o_done within %0d cycles, required one", id, budget);
        end
    endtask

    task automatic check_idle_outputs(input int id, input string tag);
        check({tag, "_valid"}, 32'(tx_valid[id]), 32'd0);
        check({tag, "_busy"},  32'(busy[id]),     32'd0);
        check({tag, "_done"},  32'(done[id]),     32'd0);
        check({tag, "_addr"},  32'(addr[id]),     32'd0);
        check({tag, "_data"},  32'(tx_data[id]),  32'd0);
    endtask

    initial begin
        int s, d0, a0, k;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; ready[i] = 1'b1;
            acc[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
            prev_stall[i] = 1'b0; prev_data[i] = 8'h00;
        end
        repeat (3) step();
        check_idle_outputs(0, "reset");

        // Start coincident with reset must be discarded.
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        step();
        check("start_in_reset_busy", 32'(busy[0]), 32'd0);

        // Basic two-word dump at full rate.
        d0 = done_cnt[0];
        push_dump(0, 2);
        pulse_start(0, s);
        wait_done(0, d0, 100);
        check("done_latency", 32'(done_cyc[0] - s), 32'd12);
        check("busy_after_done", 32'(busy[0]), 32'd0);
        check("done_pulses", 32'(done_cnt[0] - d0), 32'd1);
        check("queue_empty_t1", 32'(exp_q[0].size()), 32'd0);

        // Ready toggling every cycle.
        d0 = done_cnt[0];
        push_dump(0, 2);
        ready[0] = 1'b0;
        tog = 1'b1;
        pulse_start(0, s);
        wait_done(0, d0, 200);
        tog = 1'b0;
        step();
        ready[0] = 1'b1;
        check("queue_empty_t2", 32'(exp_q[0].size()), 32'd0);
        check("done_pulses_t2", 32'(done_cnt[0] - d0), 32'd1);

        // Restart request mid-dump must be ignored.
        d0 = done_cnt[0];
        a0 = acc[0];
        push_dump(0, 2);
        pulse_start(0, s);
        repeat (6) step();
        pulse_start(0, s);
        wait_done(0, d0, 100);
        repeat (20) step();
        check("restart_byte_count", 32'(acc[0] - a0), 32'd8);
        check("restart_busy", 32'(busy[0]), 32'd0);

        // Reset while byte 2 of word 1 is presented.
        a0 = acc[0];
        push_dump(0, 2);
        pulse_start(0, s);
        for (k = 0; k < 100 && acc[0] != a0 + 6; k++) step();
        check("reached_byte6", 32'(acc[0] - a0), 32'd6);
        rst[0] = 1'b1;
        exp_q[0].delete();
        step();
        check_idle_outputs(0, "midreset");
        rst[0] = 1'b0;
        d0 = done_cnt[0];
        push_dump(0, 2);
        pulse_start(0, s);
        wait_done(0, d0, 100);
        check("queue_empty_t4", 32'(exp_q[0].size()), 32'd0);

        // Default 64-word dump and 65-word wrap, run side by side.
        push_dump(1, 64);
        push_dump(2, 65);
        start[1] = 1'b1;
        start[2] = 1'b1;
        step();
        start[1] = 1'b0;
        start[2] = 1'b0;
        wait_done(1, 0, 1000);
        wait_done(2, 0, 1000);
        repeat (3) step();
        check("n64_bytes", 32'(acc[1]), 32'd256);
        check("n65_bytes", 32'(acc[2]), 32'd260);
        check("n64_done_pulses", 32'(done_cnt[1]), 32'd1);
        check("n65_done_pulses", 32'(done_cnt[2]), 32'd1);
        check("n64_queue_empty", 32'(exp_q[1].size()), 32'd0);
        check("n65_queue_empty", 32'(exp_q[2].size()), 32'd0);
        check("n65_busy_after", 32'(busy[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
